// File: rtl/io_console.sv
// User-side I/O responder for IN/OUT instructions: debounced enter button with switch capture,
// and a display holding register with a valid/ack handshake and sticky overrun flag.
module io_console #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              btn_raw,
   input  logic [DATA_W-1:0] sw_raw,
   output logic              enter,
   output logic [DATA_W-1:0] in_data,
   output logic              wait_user,
   input  logic              out_we,
   input  logic [DATA_W-1:0] out_din,
   output logic [DATA_W-1:0] display,
   output logic              out_valid,
   input  logic              out_ack,
   output logic              overrun
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYC);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

   typedef enum logic [2:0] {StIdle, StArm, StWaitPress, StAck, StRelease} stateT;

   logic [SYNC_STAGES-1:0] btnSync;
   logic [DATA_W-1:0]      swSync [SYNC_STAGES];
   logic                   btnS;
   logic [DATA_W-1:0]      swS;
   logic [CntW-1:0]        dbCnt;
   logic                   btnDb;
   logic                   btnDbPrev;
   logic                   btnRise;
   stateT                  stateQ;
   stateT                  stateD;
   logic                   capture;

   assign btnS    = btnSync[SYNC_STAGES-1];
   assign swS     = swSync[SYNC_STAGES-1];
   assign btnRise = btnDb & ~btnDbPrev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btnSync <= '0;
         for (int i = 0; i < int'(SYNC_STAGES); i++) swSync[i] <= '0;
      end else begin
         btnSync   <= {btnSync[SYNC_STAGES-2:0], btn_raw};
         swSync[0] <= sw_raw;
         for (int i = 1; i < int'(SYNC_STAGES); i++) swSync[i] <= swSync[i-1];
      end
   end

   // Debounced state only flips after DEBOUNCE_CYC consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbCnt     <= '0;
         btnDb     <= 1'b0;
         btnDbPrev <= 1'b0;
      end else begin
         btnDbPrev <= btnDb;
         if (btnS != btnDb) begin
            if (dbCnt == CntMax) begin
               btnDb <= ~btnDb;
               dbCnt <= '0;
            end else begin
               dbCnt <= dbCnt + CntW'(1);
            end
         end else begin
            dbCnt <= '0;
         end
      end
   end

   always_comb begin
      stateD  = stateQ;
      capture = 1'b0;
      unique case (stateQ)
         StIdle:      if (read) stateD = StArm;
         StArm: begin
            if (!read)       stateD = StIdle;
            else if (!btnDb) stateD = StWaitPress;
         end
         StWaitPress: begin
            if (!read) begin
               stateD = StIdle;
            end else if (btnRise) begin
               stateD  = StAck;
               capture = 1'b1;
            end
         end
         StAck:       stateD = StRelease;
         StRelease:   if (!btnDb) stateD = StIdle;
         default:     stateD = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= StIdle;
         enter     <= 1'b0;
         wait_user <= 1'b0;
         in_data   <= '0;
      end else begin
         stateQ    <= stateD;
         enter     <= (stateD == StAck);
         wait_user <= (stateD == StArm) || (stateD == StWaitPress);
         if (capture) in_data <= swS;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display   <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (out_we) begin
            display   <= out_din;
            out_valid <= 1'b1;
            if (out_valid && !out_ack) overrun <= 1'b1;
         end else if (out_ack) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_io_console.sv
// Self-checking bench for io_console: per-cycle model of the display side and captured word,
// plus directed IN/OUT scenarios with hand-computed expectations.
module tb_io_console;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       read = 1'b0;
   logic       btn_raw = 1'b0;
   logic [7:0] sw_raw = 8'h00;
   logic       enter;
   logic [7:0] in_data;
   logic       wait_user;
   logic       out_we = 1'b0;
   logic [7:0] out_din = 8'h00;
   logic [7:0] display;
   logic       out_valid;
   logic       out_ack = 1'b0;
   logic       overrun;

   io_console #(.DATA_W(8), .DEBOUNCE_CYC(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .read(read), .btn_raw(btn_raw), .sw_raw(sw_raw),
      .enter(enter), .in_data(in_data), .wait_user(wait_user), .out_we(out_we),
      .out_din(out_din), .display(display), .out_valid(out_valid), .out_ack(out_ack),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails = 0;
   int enterCount = 0;
   logic [7:0] curSw = 8'h00;

   logic [7:0] mDisp = 8'h00;
   logic       mValid = 1'b0;
   logic       mOvr = 1'b0;
   logic [7:0] mIn = 8'h00;
   logic       prevEnter = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: display side follows the write/ack rules; captured word is whatever the
   // switches held when the single enter pulse appears.
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         mDisp = 8'h00; mValid = 1'b0; mOvr = 1'b0; mIn = 8'h00;
      end else if (out_we) begin
         if (mValid && !out_ack) mOvr = 1'b1;
         mDisp  = out_din;
         mValid = 1'b1;
      end else if (out_ack) begin
         mValid = 1'b0;
      end
      #2;
      if (enter === 1'b1) begin
         enterCount++;
         mIn = curSw;
      end
      chk("enter one cycle wide", {31'b0, prevEnter & enter}, 32'd0);
      prevEnter = enter;
      chk("display vs model", display, mDisp);
      chk("out_valid vs model", out_valid, mValid);
      chk("overrun vs model", overrun, mOvr);
      chk("in_data vs model", in_data, mIn);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns cycles until enter, or -1 if the budget runs out.
   task automatic waitEnter(input int limit, output int n);
      int k;
      k = 0;
      n = -1;
      while (k < limit) begin
         @(posedge clk);
         #3;
         k++;
         if (enter === 1'b1) begin
            n = k;
            break;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int e0;
      int n;
      rst_n = 1'b0;
      cyc(3);
      chk("reset enter", enter, 0);
      chk("reset wait_user", wait_user, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset overrun", overrun, 0);
      chk("reset in_data", in_data, 0);
      chk("reset display", display, 0);
      rst_n = 1'b1;
      cyc(2);

      // OUT write then ack
      out_we = 1'b1; out_din = 8'h3C; cyc(1); out_we = 1'b0;
      chk("T5 display", display, 8'h3C);
      chk("T5 out_valid set", out_valid, 1);
      out_ack = 1'b1; cyc(1); out_ack = 1'b0;
      chk("T5 out_valid cleared", out_valid, 0);
      chk("T5 no overrun", overrun, 0);

      // Write while valid but acked the same cycle: no overrun
      out_we = 1'b1; out_din = 8'h44; cyc(1);
      out_din = 8'h55; out_ack = 1'b1; cyc(1);
      out_we = 1'b0; out_ack = 1'b0;
      chk("we+ack display", display, 8'h55);
      chk("we+ack out_valid", out_valid, 1);
      chk("we+ack no overrun", overrun, 0);

      // Overrun: two writes without ack
      out_ack = 1'b1; cyc(1); out_ack = 1'b0;
      out_we = 1'b1; out_din = 8'h11; cyc(1);
      chk("T6 first write no overrun", overrun, 0);
      out_din = 8'h22; cyc(1); out_we = 1'b0;
      chk("T6 display", display, 8'h22);
      chk("T6 overrun", overrun, 1);
      out_ack = 1'b1; cyc(2); out_ack = 1'b0;
      chk("ack idle out_valid", out_valid, 0);
      chk("overrun sticky", overrun, 1);

      // Reset asserted while waiting for a press
      read = 1'b1; cyc(5);
      chk("T1 waiting before reset", wait_user, 1);
      rst_n = 1'b0; read = 1'b0; #1;
      chk("T1 async wait_user", wait_user, 0);
      chk("T1 async display", display, 0);
      chk("T1 async overrun", overrun, 0);
      chk("T1 async out_valid", out_valid, 0);
      cyc(2); rst_n = 1'b1; cyc(3);
      chk("T1 idle after reset", wait_user, 0);
      read = 1'b1; cyc(3);
      chk("T1 idle accepts read", wait_user, 1);
      read = 1'b0; cyc(3);

      // IN with a bouncing button
      sw_raw = 8'hA5; curSw = 8'hA5; cyc(4);
      read = 1'b1; cyc(3);
      e0 = enterCount;
      for (int i = 0; i < 4; i++) begin
         btn_raw = ~btn_raw;
         cyc(3);
      end
      chk("T2 no enter while bouncing", enterCount - e0, 0);
      btn_raw = 1'b1;
      waitEnter(60, n);
      if (n < 18 || n > 20) $display("T2 latency observed: %0d", n);
      chk("T2 latency in window", {31'b0, (n >= 18 && n <= 20)}, 1);
      read = 1'b0;
      cyc(40);
      chk("T2 single enter", enterCount - e0, 1);
      chk("T2 in_data", in_data, 8'hA5);
      btn_raw = 1'b0; cyc(30);
      chk("T2 no enter after release", enterCount - e0, 1);

      // Stale press held before read
      sw_raw = 8'h5A; curSw = 8'h5A;
      e0 = enterCount;
      btn_raw = 1'b1; cyc(30);
      read = 1'b1; cyc(40);
      chk("T3 stale press ignored", enterCount - e0, 0);
      chk("T3 armed", wait_user, 1);
      btn_raw = 1'b0; cyc(25);
      chk("T3 no enter on release", enterCount - e0, 0);
      btn_raw = 1'b1;
      waitEnter(60, n);
      chk("T3 fresh press gives enter", {31'b0, n > 0}, 1);
      read = 1'b0; cyc(5);
      chk("T3 single enter", enterCount - e0, 1);
      chk("T3 in_data", in_data, 8'h5A);
      btn_raw = 1'b0; cyc(30);

      // Abort: read drops while waiting
      sw_raw = 8'hC3; curSw = 8'hC3;
      e0 = enterCount;
      read = 1'b1; cyc(10);
      chk("T4 waiting", wait_user, 1);
      read = 1'b0; cyc(3);
      chk("T4 abort to idle", wait_user, 0);
      btn_raw = 1'b1; cyc(40);
      chk("T4 no enter", enterCount - e0, 0);
      chk("T4 in_data unchanged", in_data, 8'h5A);
      btn_raw = 1'b0; cyc(30);
      read = 1'b1; cyc(3);
      chk("T4 idle accepts read", wait_user, 1);
      read = 1'b0; cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout reached: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
